qc_ldpc_encoder: RTL
====================

Name: qc_ldpc_encoder

Overview:
- Systematic QC-LDPC encoder. It is the transmit-side counterpart of the decoder's parity-check and judge path, and it produces codewords that satisfy the same block-circulant H.
- Default code: Z=64, 128 info block-columns and 16 block-rows. This gives 8192 info bits, 1024 parity bits and a 9216-bit codeword.
- Info arrives one circulant (Z bits) per beat. Info beats pass straight through to the output, followed by 16 parity beats.
- Parity uses a dual-diagonal (staircase, identity) parity part, so p_r = p_(r-1) xor s_r.

Parameters:
- Z, 64, circulant size and beat width in bits.
- SW, 6, shift field width; equals log2(Z).
- KB, 128, number of info block-columns.
- MB, 16, number of block-rows; equals the number of parity beats.
- AW, 7, ROM address width; equals ceil(log2(KB)).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  pulse that begins a codeword; honoured only in IDLE.
- in_data  in  Z  info circulant beat.
- in_valid  in  1  in_data valid.
- in_ready  out  1  encoder accepts in_data.
- out_data  out  Z  codeword beat.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- out_last  out  1  asserted on the final parity beat.
- rom_addr  out  AW  shift-table column address.
- rom_data  in  MB*(SW+1)  for column rom_addr: field r, at bits [r*(SW+1)+:SW+1], is {present, shift[SW-1:0]}. Synchronous ROM with 1-cycle read latency.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last parity beat is accepted.

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_last=0, out_data=0, done=0, busy=0, rom_addr=0. Reset also clears col, row, the MB syndrome registers s[0..MB-1] and p_reg, and returns the FSM to IDLE. Reset mid-codeword abandons the codeword with no output.
- State IDLE:
  - rom_addr=0.
  - On start, clear s[], p_reg, col and row, then go to FETCH.
  - start while busy is ignored.
- State FETCH:
  - Lasts exactly 1 cycle so that rom_data for column 0 becomes valid. rom_addr=0. Next state is INFO.
- State INFO:
  - Pass-through handshake: out_valid=in_valid, in_ready=out_ready, out_data=in_data.
  - A beat is accepted when in_valid & out_ready.
  - On accept at column c, for every r with present_r=1: s[r] <= s[r] xor rotr(in_data, shift_r). Define rotr(u,k)[j] = u[(j+k) mod Z]; check row j of the circulant connects to info bit (j+shift) mod Z.
  - rom_addr = col + accept (combinational lookahead), so rom_data always matches the current col with no stall cycle.
  - Accept at col=KB-1 transitions to PAR with row=0.
- State PAR:
  - in_ready=0, out_valid=1, out_data = p_reg xor s[row].
  - On out_ready: p_reg <= out_data and row increments.
  - out_last=1 when row=MB-1. Accept of that beat goes to IDLE with done=1 for 1 cycle.
- Backpressure: out_valid may be held indefinitely. out_data must stay stable while out_valid & !out_ready. No beat is ever dropped or duplicated.
- Counts per codeword: exactly KB input beats and exactly KB+MB output beats. Minimum latency from start to the first possible accept is 2 cycles (IDLE->FETCH->INFO).
- Once MB parity beats are accepted, every check row satisfies H·c = 0 over GF(2).

Test Plan:
- All-zero info, arbitrary shifts -> 144 output beats, all zero; out_last only on beat 143; done pulses once.
- Column 0 info = 64'h1, present only at (r=0, c=0) with shift=1, other columns zero -> s[0] = rotr(1,1) = 64'h8000_0000_0000_0000, so all 16 parity beats equal 64'h8000_0000_0000_0000.
- Random info and random shift table, out_ready held high -> software-model H·c over all 1024 checks is zero; exactly 144 beats in 146 cycles from start.
- Random out_ready (50%) and random in_valid gaps -> identical codeword to the no-stall run; out_data stable while stalled; rom_addr sequence is 0..127 with no skips.
- start pulsed during INFO and during PAR -> ignored; codeword unaffected; busy stays 1.
- rst_n asserted at beat 60 of INFO, then a new start -> outputs at reset values, first codeword abandoned; the new codeword is correct and independent of the old one (s[] cleared).

Source files
------------

// File: rtl/qc_ldpc_encoder.sv
`default_nettype none
// ============================================================================
// Module  : qc_ldpc_encoder
// Purpose : Systematic QC-LDPC encoder, info pass-through then staircase parity
// Revision: 1.0
// ============================================================================
module qc_ldpc_encoder #(
   parameter int Z  = 64,
   parameter int SW = 6,
   parameter int KB = 128,
   parameter int MB = 16,
   parameter int AW = 7
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [Z-1:0]         in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [Z-1:0]         out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_last,
   output logic [AW-1:0]        rom_addr,
   input  logic [MB*(SW+1)-1:0] rom_data,
   output logic                 busy,
   output logic                 done
);
   localparam int RW = (MB > 1) ? $clog2(MB) : 1;

   localparam logic [1:0] c_S_IDLE  = 2'd0;
   localparam logic [1:0] c_S_FETCH = 2'd1;
   localparam logic [1:0] c_S_INFO  = 2'd2;
   localparam logic [1:0] c_S_PAR   = 2'd3;

   localparam logic [AW-1:0] c_COL_LAST = AW'(KB - 1);
   localparam logic [RW-1:0] c_ROW_LAST = RW'(MB - 1);
   localparam logic [SW:0]   c_ZW       = (SW + 1)'(Z);

   logic [1:0]    r_state;
   logic [AW-1:0] r_col;
   logic [RW-1:0] r_row;
   logic [Z-1:0]  r_s [MB];
   logic [Z-1:0]  r_p;
   logic          r_done;

   logic          w_in_acc;
   logic          w_par_acc;
   logic          w_last_info;
   logic          w_last_par;
   logic [Z-1:0]  w_par;
   logic [Z-1:0]  w_rot [MB];
   logic [MB-1:0] w_pres;

   assign w_in_acc    = (r_state == c_S_INFO) & in_valid & out_ready;
   assign w_par_acc   = (r_state == c_S_PAR) & out_ready;
   assign w_last_info = (r_col == c_COL_LAST);
   assign w_last_par  = (r_row == c_ROW_LAST);
   assign w_par       = r_p ^ r_s[r_row];

   // Per block-row: decode {present, shift} and rotate the beat so that
   // check bit j picks up info bit (j + shift) mod Z.
   generate
      for (genvar r = 0; r < MB; r++) begin : g_row
         logic [SW:0]   w_fld;
         logic [SW-1:0] w_sh;
         assign w_fld     = rom_data[r*(SW+1) +: SW+1];
         assign w_sh      = w_fld[SW-1:0];
         assign w_pres[r] = w_fld[SW];
         assign w_rot[r]  = (in_data >> w_sh) | (in_data << (c_ZW - {1'b0, w_sh}));
      end
   endgenerate

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_data  = '0;
      out_last  = 1'b0;
      rom_addr  = '0;
      case (r_state)
         c_S_INFO: begin
            in_ready  = out_ready;
            out_valid = in_valid;
            out_data  = in_data;
            // Lookahead keeps rom_data aligned with r_col despite the read latency
            rom_addr  = r_col + AW'(w_in_acc);
         end
         c_S_PAR: begin
            out_valid = 1'b1;
            out_data  = w_par;
            out_last  = w_last_par;
         end
         default: ;
      endcase
   end

   assign busy = (r_state != c_S_IDLE);
   assign done = r_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_S_IDLE;
         r_col   <= '0;
         r_row   <= '0;
         r_p     <= '0;
         r_done  <= 1'b0;
         for (int r = 0; r < MB; r++) r_s[r] <= '0;
      end else begin
         r_done <= w_par_acc & w_last_par;
         case (r_state)
            c_S_IDLE: begin
               if (start) begin
                  r_col   <= '0;
                  r_row   <= '0;
                  r_p     <= '0;
                  for (int r = 0; r < MB; r++) r_s[r] <= '0;
                  r_state <= c_S_FETCH;
               end
            end
            c_S_FETCH: r_state <= c_S_INFO;
            c_S_INFO: begin
               if (w_in_acc) begin
                  for (int r = 0; r < MB; r++)
                     if (w_pres[r]) r_s[r] <= r_s[r] ^ w_rot[r];
                  r_col <= r_col + 1'b1;
                  if (w_last_info) begin
                     r_row   <= '0;
                     r_state <= c_S_PAR;
                  end
               end
            end
            c_S_PAR: begin
               if (out_ready) begin
                  r_p   <= w_par;
                  r_row <= r_row + 1'b1;
                  if (w_last_par) r_state <= c_S_IDLE;
               end
            end
            default: r_state <= c_S_IDLE;
         endcase
      end
   end
endmodule
`default_nettype wire
